// File: rtl/ctrl_issue_unit_if.sv
// Issue-side and bundle-side handshake bundle for ctrl_issue_unit.
// The slave side is the issue unit; the master side is the pipeline around it
// (IF/ID register feeding instructions, ID/EX register consuming bundles).
interface ctrl_issue_unit_if #(
    parameter int REG_W = 4
);
    // IF/ID side
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       instruction_type;
    logic [4:0]       func;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;

    // ID/EX side
    logic             out_valid;
    logic             out_ready;
    logic             JumpI;
    logic             JumpCI;
    logic             JumpCD;
    logic             MemToReg;
    logic             MemRead;
    logic             MemWrite;
    logic             ALUSrc;
    logic             RegWrite;
    logic             RegSrc2;
    logic [2:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic [1:0]       RegDtn;
    logic [1:0]       RegSrc1;
    logic [REG_W-1:0] out_rd;
    logic             illegal;

    modport slave (
        input  in_valid, instruction_type, func, rd, rs1, rs2, out_ready,
        output in_ready, out_valid, JumpI, JumpCI, JumpCD, MemToReg, MemRead,
               MemWrite, ALUSrc, RegWrite, RegSrc2, ALUOp, ImmSrc, RegDtn,
               RegSrc1, out_rd, illegal
    );

    modport master (
        output in_valid, instruction_type, func, rd, rs1, rs2, out_ready,
        input  in_ready, out_valid, JumpI, JumpCI, JumpCD, MemToReg, MemRead,
               MemWrite, ALUSrc, RegWrite, RegSrc2, ALUOp, ImmSrc, RegDtn,
               RegSrc1, out_rd, illegal
    );
endinterface

// File: rtl/ctrl_issue_unit.sv
// Registered decode-and-issue stage. Decodes instruction_type/func into the
// EX control bundle, holds it in an output register, and stalls issue for
// load-use hazards, multi-cycle MUL/DIV occupancy and pending branches.
module ctrl_issue_unit #(
    parameter int REG_W      = 4,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_issue_unit_if.slave    bus,
    input  logic                flush,
    input  logic                br_resolve,
    output logic                busy
);
    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BUSY    = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic       jump_i;
        logic       jump_ci;
        logic       jump_cd;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       reg_src2;
        logic [2:0] alu_op;
        logic [1:0] imm_src;
        logic [1:0] reg_dtn;
        logic [1:0] reg_src1;
        logic       illegal;
    } ctrl_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu_pending;
    logic [REG_W-1:0] lu_rd;
    logic             out_valid_q;
    ctrl_t            bundle_q;
    logic [REG_W-1:0] rd_q;

    ctrl_t dec;
    logic  use_rs1, use_rs2;
    logic  is_crg, is_mul, is_div, is_branch;
    logic  hazard, accept;

    // Decode the presented instruction into a control bundle plus hazard/occupancy tags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        dec       = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_crg    = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_branch = 1'b0;
        case (bus.instruction_type)
            2'b10: begin
                if (bus.func[2:0] > 3'd4 || bus.func[4:3] == 2'b10) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_write = 1'b1;
                    dec.reg_dtn   = 2'b01;
                    dec.reg_src1  = 2'b10;
                    dec.alu_op    = bus.func[2:0];
                    use_rs1       = 1'b1;
                    is_mul        = (bus.func[2:0] == 3'd2);
                    is_div        = (bus.func[2:0] == 3'd3);
                    if (bus.func[4]) begin
                        // immediate form: second operand comes from the immediate
                        dec.alu_src = 1'b1;
                        dec.imm_src = 2'b10;
                    end else begin
                        dec.reg_src2 = 1'b1;
                        use_rs2      = 1'b1;
                    end
                end
            end
            2'b00: begin
                if (bus.func == 5'b00000 || bus.func == 5'b00010 || bus.func == 5'b00011) begin
                    dec.alu_op  = 3'b001;
                    dec.jump_i  = (bus.func == 5'b00000);
                    dec.jump_ci = (bus.func == 5'b00010);
                    dec.jump_cd = (bus.func == 5'b00011);
                    use_rs1     = 1'b1;
                    use_rs2     = 1'b1;
                    is_branch   = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            2'b01: begin
                if (bus.func == 5'b00000 || bus.func == 5'b00001) begin
                    dec.alu_src  = 1'b1;
                    dec.imm_src  = 2'b01;
                    dec.reg_src1 = 2'b01;
                    use_rs1      = 1'b1;
                    if (bus.func[0]) begin
                        // CRG: load into a register
                        dec.mem_read   = 1'b1;
                        dec.mem_to_reg = 1'b1;
                        dec.reg_write  = 1'b1;
                        is_crg         = 1'b1;
                    end else begin
                        // GDR: store, rs2 supplies the data
                        dec.mem_write = 1'b1;
                        use_rs2       = 1'b1;
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Illegal encodings read no registers, so they never wait on a load.
    assign hazard = lu_pending &&
                    ((use_rs1 && bus.rs1 == lu_rd) || (use_rs2 && bus.rs2 == lu_rd));

    assign bus.in_ready = !rst && (state == ST_RUN) && (!out_valid_q || bus.out_ready) &&
                          !hazard && !flush;
    assign accept = bus.in_valid && bus.in_ready;

    // Issue FSM, load-use tracker and output register, all updated together.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            busy        <= 1'b0;
            lu_pending  <= 1'b0;
            lu_rd       <= '0;
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
            rd_q        <= '0;
        end else if (flush) begin
            // bundle fields hold; only validity and interlocks are dropped
            state       <= ST_RUN;
            cnt         <= '0;
            busy        <= 1'b0;
            lu_pending  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                bundle_q    <= dec;
                rd_q        <= bus.rd;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // a new CRG re-arms the interlock even as the previous one drains
            if (accept && is_crg) begin
                lu_pending <= 1'b1;
                lu_rd      <= bus.rd;
            end else if (out_valid_q && bus.out_ready) begin
                lu_pending <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (is_mul && MUL_CYCLES > 1) begin
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(MUL_CYCLES - 1);
                        end else if (is_div && DIV_CYCLES > 1) begin
                            state <= ST_BUSY;
                            busy  <= 1'b1;
                            cnt   <= CNT_W'(DIV_CYCLES - 1);
                        end else if (is_branch) begin
                            state <= ST_BR_WAIT;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_BR_WAIT: begin
                    if (br_resolve) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.JumpI     = bundle_q.jump_i;
    assign bus.JumpCI    = bundle_q.jump_ci;
    assign bus.JumpCD    = bundle_q.jump_cd;
    assign bus.MemToReg  = bundle_q.mem_to_reg;
    assign bus.MemRead   = bundle_q.mem_read;
    assign bus.MemWrite  = bundle_q.mem_write;
    assign bus.ALUSrc    = bundle_q.alu_src;
    assign bus.RegWrite  = bundle_q.reg_write;
    assign bus.RegSrc2   = bundle_q.reg_src2;
    assign bus.ALUOp     = bundle_q.alu_op;
    assign bus.ImmSrc    = bundle_q.imm_src;
    assign bus.RegDtn    = bundle_q.reg_dtn;
    assign bus.RegSrc1   = bundle_q.reg_src1;
    assign bus.illegal   = bundle_q.illegal;
    assign bus.out_rd    = rd_q;
endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Self-checking bench for ctrl_issue_unit: directed scenarios followed by
// random traffic, both checked every cycle against a mnemonic-level model.
module tb_ctrl_issue_unit;
    localparam int REG_W      = 4;
    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 8;

    localparam logic [6:0] E_IDLE = 7'b10_00000;
    localparam logic [6:0] E_SUM  = 7'b10_00000;
    localparam logic [6:0] E_SUMI = 7'b10_11000;
    localparam logic [6:0] E_DIV  = 7'b10_00011;
    localparam logic [6:0] E_RSD  = 7'b10_00100;
    localparam logic [6:0] E_SCI  = 7'b00_00010;
    localparam logic [6:0] E_CRG  = 7'b01_00001;
    localparam logic [6:0] E_ILL  = 7'b11_00101;

    typedef enum int {
        M_SUM, M_RES, M_MUL, M_DIV, M_RSD,
        M_SUMI, M_RESI, M_MULI, M_DIVI, M_RSDI,
        M_SI, M_SCI, M_SCD, M_GDR, M_CRG, M_ILL
    } mn_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic br_resolve;
    logic busy;

    ctrl_issue_unit_if #(.REG_W(REG_W)) bus ();

    ctrl_issue_unit #(
        .REG_W(REG_W), .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .flush(flush),
        .br_resolve(br_resolve), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // reference model state
    logic              m_out_valid = 1'b0;
    logic [18:0]       m_bundle    = '0;
    logic [REG_W-1:0]  m_rd        = '0;
    int                m_lu        = -1;
    int                m_block     = 0;
    logic              m_br_wait   = 1'b0;

    // observations latched by step() at its sampling point
    logic              obs_ready, obs_busy, obs_valid;

    logic [6:0] enc_tab [0:15];

    // Compare and count; every mismatch reports once.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic mn_t classify(input logic [1:0] t, input logic [4:0] f);
        mn_t m;
        m = M_ILL;
        if (t == 2'b10 && f[2:0] <= 3'd4) begin
            if (!f[4])             m = mn_t'(int'(M_SUM)  + int'(f[2:0]));
            else if (f[3])         m = mn_t'(int'(M_SUMI) + int'(f[2:0]));
        end else if (t == 2'b00) begin
            if (f == 5'd0)         m = M_SI;
            else if (f == 5'd2)    m = M_SCI;
            else if (f == 5'd3)    m = M_SCD;
        end else if (t == 2'b01) begin
            if (f == 5'd0)         m = M_GDR;
            else if (f == 5'd1)    m = M_CRG;
        end
        return m;
    endfunction

    // {reads rs1, reads rs2}
    function automatic logic [1:0] sources(input mn_t m);
        if (m == M_ILL) return 2'b00;
        if (m >= M_SUMI && m <= M_RSDI) return 2'b10;
        if (m == M_CRG) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [18:0] ref_bundle(input mn_t m);
        logic ji, jci, jcd, m2r, mrd, mwr, asrc, rw, rs2s, ill;
        logic [2:0] op;
        logic [1:0] imm, dtn, rs1s;
        {ji, jci, jcd, m2r, mrd, mwr, asrc, rw, rs2s, ill} = '0;
        op = '0; imm = '0; dtn = '0; rs1s = '0;
        if (m <= M_RSD) begin
            rw = 1; dtn = 2'b01; rs2s = 1; rs1s = 2'b10; op = 3'(int'(m) - int'(M_SUM));
        end else if (m <= M_RSDI) begin
            rw = 1; dtn = 2'b01; asrc = 1; imm = 2'b10; rs1s = 2'b10;
            op = 3'(int'(m) - int'(M_SUMI));
        end else if (m == M_SI || m == M_SCI || m == M_SCD) begin
            op = 3'b001; ji = (m == M_SI); jci = (m == M_SCI); jcd = (m == M_SCD);
        end else if (m == M_GDR) begin
            asrc = 1; imm = 2'b01; rs1s = 2'b01; mwr = 1;
        end else if (m == M_CRG) begin
            asrc = 1; imm = 2'b01; rs1s = 2'b01; mrd = 1; m2r = 1; rw = 1;
        end else begin
            ill = 1;
        end
        return {ji, jci, jcd, m2r, mrd, mwr, asrc, rw, rs2s, op, imm, dtn, rs1s, ill};
    endfunction

    function automatic logic [18:0] dut_bundle();
        return {bus.JumpI, bus.JumpCI, bus.JumpCD, bus.MemToReg, bus.MemRead,
                bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.RegSrc2, bus.ALUOp,
                bus.ImmSrc, bus.RegDtn, bus.RegSrc1, bus.illegal};
    endfunction

    task automatic drive(input logic v, input logic [6:0] enc, input int d, input int s1, input int s2);
        bus.in_valid         = v;
        bus.instruction_type = enc[6:5];
        bus.func             = enc[4:0];
        bus.rd               = REG_W'(d);
        bus.rs1              = REG_W'(s1);
        bus.rs2              = REG_W'(s2);
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        mn_t m;
        logic [1:0] src;
        logic hz, exp_ready, acc, consumed;
        #1;
        m   = classify(bus.instruction_type, bus.func);
        src = sources(m);
        hz  = (m_lu >= 0) && ((src[1] && int'(bus.rs1) == m_lu) ||
                              (src[0] && int'(bus.rs2) == m_lu));
        exp_ready = !rst && m_block == 0 && !m_br_wait &&
                    (!m_out_valid || bus.out_ready) && !hz && !flush;
        obs_ready = bus.in_ready;
        obs_busy  = busy;
        obs_valid = bus.out_valid;
        check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
        check("busy",      32'(busy),          32'(m_block > 0 || m_br_wait));
        check("bundle",    32'(dut_bundle()),  32'(m_bundle));
        check("out_rd",    32'(bus.out_rd),    32'(m_rd));
        acc = bus.in_valid && exp_ready;
        @(posedge clk);
        if (rst) begin
            m_out_valid = 0; m_bundle = '0; m_rd = '0; m_lu = -1; m_block = 0; m_br_wait = 0;
        end else if (flush) begin
            m_out_valid = 0; m_lu = -1; m_block = 0; m_br_wait = 0;
        end else begin
            consumed = m_out_valid && bus.out_ready;
            if (m_block > 0) m_block--;
            if (m_br_wait && br_resolve) m_br_wait = 0;
            if (acc) begin
                m_bundle    = ref_bundle(m);
                m_rd        = bus.rd;
                m_out_valid = 1;
                if (m == M_MUL || m == M_MULI) m_block = MUL_CYCLES - 1;
                if (m == M_DIV || m == M_DIVI) m_block = DIV_CYCLES - 1;
                if (m == M_SI || m == M_SCI || m == M_SCD) m_br_wait = 1;
            end else if (bus.out_ready) begin
                m_out_valid = 0;
            end
            if (acc && m == M_CRG) m_lu = int'(bus.rd);
            else if (consumed)     m_lu = -1;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int stall, busyc;
        logic done;
        logic [18:0] held;

        enc_tab = '{7'b10_00000, 7'b10_00001, 7'b10_00010, 7'b10_00011,
                    7'b10_00100, 7'b10_11000, 7'b10_11001, 7'b10_11010,
                    7'b10_11011, 7'b10_11100, 7'b00_00000, 7'b00_00010,
                    7'b00_00011, 7'b01_00000, 7'b01_00001, 7'b01_00001};

        rst = 1; flush = 0; br_resolve = 0; bus.out_ready = 1;
        drive(0, E_IDLE, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        step(); step();
        rst = 0;
        step();

        // back-to-back SUM then SUMI
        drive(1, E_SUM, 1, 2, 4); step();
        check("sum_aluop",  32'(bus.ALUOp),   32'd0);
        check("sum_alusrc", 32'(bus.ALUSrc),  32'd0);
        check("sum_regsrc2",32'(bus.RegSrc2), 32'd1);
        drive(1, E_SUMI, 2, 3, 0); step();
        check("sumi_valid", 32'(bus.out_valid), 32'd1);
        check("sumi_alusrc",32'(bus.ALUSrc),  32'd1);
        check("sumi_immsrc",32'(bus.ImmSrc),  32'd2);

        // load-use with dependency: one bubble
        drive(1, E_CRG, 3, 1, 2); step();
        drive(1, E_SUM, 4, 5, 3); step();
        check("lu_stall", 32'(obs_ready), 32'd0);
        step();
        check("lu_bubble", 32'(obs_valid), 32'd0);
        check("lu_accept", 32'(obs_ready), 32'd1);
        drive(0, E_IDLE, 0, 0, 0);
        check("lu_consumer_rd", 32'(bus.out_rd), 32'd4);
        step();

        // load-use without dependency: no bubble
        drive(1, E_CRG, 3, 1, 2); step();
        drive(1, E_SUM, 4, 5, 6); step();
        check("nolu_accept", 32'(obs_ready), 32'd1);
        drive(0, E_IDLE, 0, 0, 0); step();
        check("nolu_valid", 32'(obs_valid), 32'd1);

        // divide occupancy
        drive(1, E_DIV, 1, 7, 8); step();
        drive(1, E_SUM, 2, 9, 10);
        stall = 0; busyc = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (!obs_ready) stall++;
            if (obs_busy) busyc++;
            if (obs_ready) done = 1;
        end
        check("div_stall_cycles", 32'(stall), 32'(DIV_CYCLES - 1));
        check("div_busy_cycles",  32'(busyc), 32'(DIV_CYCLES - 1));
        drive(0, E_IDLE, 0, 0, 0); step();

        // divide abandoned by flush in its third busy cycle
        drive(1, E_DIV, 1, 7, 8); step();
        drive(0, E_IDLE, 0, 0, 0); step(); step();
        flush = 1; step(); flush = 0;
        drive(1, E_SUM, 2, 9, 10); step();
        check("div_flush_ready", 32'(obs_ready), 32'd1);
        check("div_flush_busy",  32'(obs_busy),  32'd0);
        drive(0, E_IDLE, 0, 0, 0); step();

        // branch wait released by br_resolve
        drive(1, E_SCI, 0, 1, 2); step();
        check("sci_jumpci", 32'(bus.JumpCI), 32'd1);
        drive(1, E_SUM, 5, 11, 12); step();
        check("br_wait_block", 32'(obs_ready), 32'd0);
        step();
        br_resolve = 1; step(); br_resolve = 0;
        check("br_resolve_edge_block", 32'(obs_ready), 32'd0);
        step();
        check("br_resolve_accept", 32'(obs_ready), 32'd1);
        drive(0, E_IDLE, 0, 0, 0); step();

        // branch wait cleared by flush
        drive(1, E_SCI, 0, 1, 2); step();
        drive(1, E_SUM, 5, 11, 12); step();
        flush = 1; step(); flush = 0;
        check("br_flush_valid", 32'(bus.out_valid), 32'd0);
        check("br_flush_busy",  32'(busy),          32'd0);
        step();
        check("br_flush_accept", 32'(obs_ready), 32'd1);
        drive(0, E_IDLE, 0, 0, 0); step();

        // illegal encoding
        drive(1, E_ILL, 6, 0, 0); step();
        check("illegal_flag",    32'(bus.illegal),   32'd1);
        check("illegal_enables", 32'(dut_bundle()),  32'd1);

        // backpressure holds the bundle
        drive(1, E_SUM, 2, 1, 1); step();
        bus.out_ready = 0;
        drive(1, E_RSD, 7, 13, 14);
        held = dut_bundle();
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold",  32'(dut_bundle()), 32'(held));
            check("bp_ready", 32'(obs_ready),    32'd0);
        end
        bus.out_ready = 1; step();
        drive(0, E_IDLE, 0, 0, 0); step();

        // reset in the middle of a divide
        drive(1, E_DIV, 1, 2, 3); step();
        drive(0, E_IDLE, 0, 0, 0); step(); step();
        rst = 1; step(); step(); rst = 0;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_zero",  32'(dut_bundle()),  32'd0);
        step();
        check("rst_ready", 32'(obs_ready), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] enc;
            enc = ($urandom_range(99) < 85) ? enc_tab[$urandom_range(15)] : 7'($urandom);
            drive(($urandom_range(99) < 75), enc, $urandom_range(3),
                  $urandom_range(3), $urandom_range(3));
            bus.out_ready = ($urandom_range(99) < 80);
            flush         = ($urandom_range(99) < 3);
            br_resolve    = ($urandom_range(99) < 20);
            step();
        end
        flush = 0; br_resolve = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
